// File: rtl/gate_chk_pkg.sv
// Shared types and reference truth tables for the gate truth checker.
// Truth tables are indexed by the input vector {A,B}: bit i is the
// expected gate output when in_vec == i.
package gate_chk_pkg;

   // Sweep sequencer states
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      SAMPLE = 2'd2,
      DONE   = 2'd3
   } state_e;

   // Two-input truth tables, bit index = {A,B}
   localparam logic [3:0] TT_OR   = 4'b1110;
   localparam logic [3:0] TT_AND  = 4'b1000;
   localparam logic [3:0] TT_NAND = 4'b0111;
   localparam logic [3:0] TT_NOR  = 4'b0001;
   localparam logic [3:0] TT_XOR  = 4'b0110;
   localparam logic [3:0] TT_XNOR = 4'b1001;

endpackage

// File: rtl/gate_chk_settle_cnt.sv
// Loadable down-counter that times the settle window of each vector.
// tc_o is high while the count is zero, i.e. in the last settle cycle.
module gate_chk_settle_cnt
   import gate_chk_pkg::*;
#(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         dec_i,
   output logic         tc_o
);

   localparam logic [W-1:0] CNT_ZERO = W'(0);
   localparam logic [W-1:0] CNT_ONE  = W'(1);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   // Next count: load has priority, decrement stops at zero
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (dec_i && (cnt_q != CNT_ZERO)) begin
         cnt_d = cnt_q - CNT_ONE;
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Count register, cleared by reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= CNT_ZERO;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tc_o = (cnt_q == CNT_ZERO);

endmodule

// File: rtl/gate_truth_checker.sv
// Clocked stimulus-and-check wrapper for a small combinational gate.
// Walks in_vec through every input combination, holds each vector for
// SETTLE_CYC cycles, samples y_in for one cycle and compares against
// EXP_TABLE. Results (pass, err_count, fail_vec) stay valid while done=1.
module gate_truth_checker
   import gate_chk_pkg::*;
#(
   parameter int                    N_IN       = 2,
   parameter int                    SETTLE_CYC = 2,
   parameter logic [(2**N_IN)-1:0]  EXP_TABLE  = 4'b1110
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   output logic [N_IN-1:0]        in_vec,
   input  logic                   y_in,
   output logic                   busy,
   output logic                   done,
   output logic                   pass,
   output logic [N_IN:0]          err_count,
   output logic [(2**N_IN)-1:0]   fail_vec
);

   localparam int NV    = 2 ** N_IN;
   localparam int ERR_W = N_IN + 1;
   localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

   localparam logic [N_IN-1:0]  IDX_ZERO    = N_IN'(0);
   localparam logic [N_IN-1:0]  IDX_ONE     = N_IN'(1);
   localparam logic [N_IN-1:0]  IDX_LAST    = N_IN'(NV - 1);
   localparam logic [ERR_W-1:0] ERR_ZERO    = ERR_W'(0);
   localparam logic [ERR_W-1:0] ERR_ONE     = ERR_W'(1);
   localparam logic [ERR_W-1:0] ERR_MAX     = ERR_W'(NV);
   localparam logic [NV-1:0]    FAIL_ZERO   = NV'(0);
   localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYC - 1);

   // Reject illegal parameterisations at elaboration time
   generate
      if (SETTLE_CYC < 1) begin : g_bad_settle
         $error("gate_truth_checker: SETTLE_CYC must be at least 1");
      end
      if ((N_IN < 1) || (N_IN > 4)) begin : g_bad_nin
         $error("gate_truth_checker: N_IN must be in 1..4");
      end
   endgenerate

   state_e            state_q, state_d;
   logic [N_IN-1:0]   idx_q, idx_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              pass_q, pass_d;
   logic [ERR_W-1:0]  err_q, err_d;
   logic [NV-1:0]     fail_q, fail_d;

   logic              cnt_load_s;
   logic              cnt_dec_s;
   logic              cnt_tc_s;
   logic              mismatch_s;
   logic [ERR_W-1:0]  err_next_s;

   gate_chk_settle_cnt #(
      .W (CNT_W)
   ) u_settle_cnt (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_i     (cnt_load_s),
      .load_val_i (SETTLE_LOAD),
      .dec_i      (cnt_dec_s),
      .tc_o       (cnt_tc_s)
   );

   // Compare the sampled gate output and form the saturating error count
   always_comb begin
      mismatch_s = (y_in != EXP_TABLE[idx_q]);
      err_next_s = err_q;
      if (mismatch_s && (err_q != ERR_MAX)) begin
         err_next_s = err_q + ERR_ONE;
      end else begin
         err_next_s = err_q;
      end
   end

   // Sweep sequencer: next state, vector index, result and counter controls
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      busy_d     = busy_q;
      done_d     = done_q;
      pass_d     = pass_q;
      err_d      = err_q;
      fail_d     = fail_q;
      cnt_load_s = 1'b0;
      cnt_dec_s  = 1'b0;

      case (state_q)
         IDLE, DONE: begin
            // A start from DONE is a full restart that discards old results
            if (start) begin
               state_d    = SETTLE;
               idx_d      = IDX_ZERO;
               busy_d     = 1'b1;
               done_d     = 1'b0;
               pass_d     = 1'b0;
               err_d      = ERR_ZERO;
               fail_d     = FAIL_ZERO;
               cnt_load_s = 1'b1;
            end else begin
               state_d = state_q;
            end
         end

         SETTLE: begin
            if (cnt_tc_s) begin
               state_d = SAMPLE;
            end else begin
               cnt_dec_s = 1'b1;
            end
         end

         SAMPLE: begin
            err_d = err_next_s;
            if (mismatch_s) begin
               fail_d[idx_q] = 1'b1;
            end else begin
               fail_d = fail_q;
            end
            if (idx_q == IDX_LAST) begin
               // Pass must reflect the result of this final sample too
               state_d = DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               pass_d  = (err_next_s == ERR_ZERO);
            end else begin
               state_d    = SETTLE;
               idx_d      = idx_q + IDX_ONE;
               cnt_load_s = 1'b1;
            end
         end

         default: begin
            state_d = IDLE;
            idx_d   = IDX_ZERO;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            pass_d  = 1'b0;
            err_d   = ERR_ZERO;
            fail_d  = FAIL_ZERO;
         end
      endcase
   end

   // State and result registers; reset discards any partial sweep
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= IDX_ZERO;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
         err_q   <= ERR_ZERO;
         fail_q  <= FAIL_ZERO;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
         err_q   <= err_d;
         fail_q  <= fail_d;
      end
   end

   // The vector index register drives the gate directly, so in_vec is glitch-free
   assign in_vec    = idx_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign pass      = pass_q;
   assign err_count = err_q;
   assign fail_vec  = fail_q;

endmodule

// File: tb/tb_gate_truth_checker.sv
// Bench for gate_truth_checker. Three instances: OR table / settle 2,
// AND table / settle 2, OR table / settle 1. Each drives a behavioural
// "gate" whose truth table the bench chooses; expected results come from
// the gate table versus the reference table and from the sweep timing
// (NV*(SETTLE+1) cycles, vector j/(SETTLE+1) after cycle j).
module tb_gate_truth_checker;

   localparam logic [3:0] G_OR  = 4'b1110;
   localparam logic [3:0] G_AND = 4'b1000;

   logic clk = 1'b0;
   logic rst_n;

   logic       start_s [3];
   logic [3:0] gate_tt [3];
   logic [1:0] vec_s   [3];
   logic       y_s     [3];
   logic       busy_s  [3];
   logic       done_s  [3];
   logic       pass_s  [3];
   logic [2:0] err_s   [3];
   logic [3:0] fail_s  [3];

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   // Behavioural gates under test
   assign y_s[0] = gate_tt[0][vec_s[0]];
   assign y_s[1] = gate_tt[1][vec_s[1]];
   assign y_s[2] = gate_tt[2][vec_s[2]];

   gate_truth_checker #(.N_IN(2), .SETTLE_CYC(2), .EXP_TABLE(G_OR)) u_or (
      .clk(clk), .rst_n(rst_n), .start(start_s[0]), .in_vec(vec_s[0]), .y_in(y_s[0]),
      .busy(busy_s[0]), .done(done_s[0]), .pass(pass_s[0]),
      .err_count(err_s[0]), .fail_vec(fail_s[0]));

   gate_truth_checker #(.N_IN(2), .SETTLE_CYC(2), .EXP_TABLE(G_AND)) u_and (
      .clk(clk), .rst_n(rst_n), .start(start_s[1]), .in_vec(vec_s[1]), .y_in(y_s[1]),
      .busy(busy_s[1]), .done(done_s[1]), .pass(pass_s[1]),
      .err_count(err_s[1]), .fail_vec(fail_s[1]));

   gate_truth_checker #(.N_IN(2), .SETTLE_CYC(1), .EXP_TABLE(G_OR)) u_s1 (
      .clk(clk), .rst_n(rst_n), .start(start_s[2]), .in_vec(vec_s[2]), .y_in(y_s[2]),
      .busy(busy_s[2]), .done(done_s[2]), .pass(pass_s[2]),
      .err_count(err_s[2]), .fail_vec(fail_s[2]));

   function automatic logic [3:0] exp_of(input int d);
      if (d == 1) return G_AND;
      return G_OR;
   endfunction

   function automatic int settle_of(input int d);
      if (d == 2) return 1;
      return 2;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One full sweep on instance d with the given gate; optional extra start
   // pulse sampled at edge k+mid (mid < 0: none). Checks every cycle.
   task automatic do_sweep(input int d, input logic [3:0] gate, input int mid);
      int s, len, eerr;
      logic [3:0] efail;
      logic [1:0] evec;
      s     = settle_of(d);
      len   = 4 * (s + 1);
      efail = gate ^ exp_of(d);
      eerr  = $countones(efail);
      gate_tt[d] = gate;
      start_s[d] = 1'b1;
      step();
      start_s[d] = 1'b0;
      for (int j = 0; j < len; j++) begin
         evec = 2'(j / (s + 1));
         n_cmp++;
         if (vec_s[d] !== evec) begin
            n_bad++;
            $display("FAIL in_vec dut%0d cyc%0d: got %0d expected %0d", d, j, vec_s[d], evec);
         end
         n_cmp++;
         if ((busy_s[d] !== 1'b1) || (done_s[d] !== 1'b0)) begin
            n_bad++;
            $display("FAIL busy_done dut%0d cyc%0d: got %b%b expected 10", d, j, busy_s[d], done_s[d]);
         end
         if (j == 0) begin
            n_cmp++;
            if ((err_s[d] !== 3'd0) || (fail_s[d] !== 4'd0) || (pass_s[d] !== 1'b0)) begin
               n_bad++;
               $display("FAIL start_clear dut%0d: got err=%0d fail=%b pass=%b expected 0 0000 0",
                        d, err_s[d], fail_s[d], pass_s[d]);
            end
         end
         start_s[d] = ((mid >= 0) && (j + 1 == mid)) ? 1'b1 : 1'b0;
         step();
      end
      start_s[d] = 1'b0;
      for (int h = 0; h < 2; h++) begin
         n_cmp++;
         if ((done_s[d] !== 1'b1) || (busy_s[d] !== 1'b0) || (vec_s[d] !== 2'd3)) begin
            n_bad++;
            $display("FAIL done_state dut%0d hold%0d: got done=%b busy=%b vec=%0d expected 1 0 3",
                     d, h, done_s[d], busy_s[d], vec_s[d]);
         end
         n_cmp++;
         if ((err_s[d] !== 3'(eerr)) || (fail_s[d] !== efail) || (pass_s[d] !== (efail == 4'd0))) begin
            n_bad++;
            $display("FAIL results dut%0d gate=%b: got err=%0d fail=%b pass=%b expected %0d %b %b",
                     d, gate, err_s[d], fail_s[d], pass_s[d], eerr, efail, (efail == 4'd0));
         end
         step();
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      for (int d = 0; d < 3; d++) begin
         start_s[d] = 1'b0;
         gate_tt[d] = 4'd0;
      end
      step();
      step();
      for (int d = 0; d < 3; d++) begin
         n_cmp++;
         if ((vec_s[d] !== 2'd0) || (busy_s[d] !== 1'b0) || (done_s[d] !== 1'b0) ||
             (pass_s[d] !== 1'b0) || (err_s[d] !== 3'd0) || (fail_s[d] !== 4'd0)) begin
            n_bad++;
            $display("FAIL reset dut%0d: got vec=%0d busy=%b done=%b pass=%b err=%0d fail=%b expected all 0",
                     d, vec_s[d], busy_s[d], done_s[d], pass_s[d], err_s[d], fail_s[d]);
         end
      end
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_reset_mid();
      gate_tt[0] = 4'b0000;
      start_s[0] = 1'b1;
      step();
      start_s[0] = 1'b0;
      for (int j = 0; j < 7; j++) step();
      n_cmp++;
      if (vec_s[0] !== 2'd2) begin
         n_bad++;
         $display("FAIL pre_reset_vec: got %0d expected 2", vec_s[0]);
      end
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if ((vec_s[0] !== 2'd0) || (busy_s[0] !== 1'b0) || (done_s[0] !== 1'b0) ||
          (pass_s[0] !== 1'b0) || (err_s[0] !== 3'd0) || (fail_s[0] !== 4'd0)) begin
         n_bad++;
         $display("FAIL async_reset: got vec=%0d busy=%b done=%b pass=%b err=%0d fail=%b expected all 0",
                  vec_s[0], busy_s[0], done_s[0], pass_s[0], err_s[0], fail_s[0]);
      end
      step();
      step();
      rst_n = 1'b1;
      for (int j = 0; j < 4; j++) begin
         step();
         n_cmp++;
         if ((busy_s[0] !== 1'b0) || (done_s[0] !== 1'b0) || (vec_s[0] !== 2'd0)) begin
            n_bad++;
            $display("FAIL idle_after_reset cyc%0d: got busy=%b done=%b vec=%0d expected 0 0 0",
                     j, busy_s[0], done_s[0], vec_s[0]);
         end
      end
      do_sweep(0, G_OR, -1);
   endtask

   task automatic test_random();
      int d, s, mid;
      logic [3:0] g;
      for (int r = 0; r < 8; r++) begin
         d   = int'($urandom_range(0, 2));
         s   = settle_of(d);
         g   = 4'($urandom);
         mid = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 4 * (s + 1) - 1)) : -1;
         do_sweep(d, g, mid);
      end
   endtask

   initial begin
      test_reset();
      do_sweep(0, G_OR, -1);        // correct OR gate
      do_sweep(0, 4'b0000, -1);     // stuck-at-0 output: err 3, fail 1110
      do_sweep(0, G_AND, -1);       // AND against OR table: err 2, fail 0110
      do_sweep(0, 4'b0001, -1);     // every vector wrong: err reaches NV
      do_sweep(1, G_OR, -1);        // OR gate against AND table
      do_sweep(1, G_AND, -1);       // restart from DONE with matching gate
      do_sweep(0, G_AND, 5);        // start at k+5 ignored
      test_reset_mid();
      do_sweep(2, G_OR, -1);        // settle of 1: 8-cycle sweep
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
